r4_butter_seq: RTL and testbench

//  Sequencer for the combinational radix-4 butterfly datapath. Accepts one frame of four complex

---
 rtl/r4_butter_seq.sv | 165 ++++++++++++++++
 tb/tb_r4_butter_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/r4_butter_seq.sv
// ---------------------------------------------------------------------------
// r4_butter_seq
//   Sequencer for a combinational radix-4 butterfly. A frame of four complex
//   operands is accepted over a valid/ready handshake and registered onto the
//   butterfly inputs. The c1/c2/c3 controls are then stepped through four
//   output indices. For each index the controls are held for SETTLE cycles,
//   the butterfly result is captured, and it is streamed out over a second
//   valid/ready handshake.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous abort of the current frame
//   in_valid/in_ready       frame handshake (in_ready only in IDLE)
//   in_data                 {xi3,xr3,xi2,xr2,xi1,xr1,xi0,xr0}, xr0 at LSBs
//   bf_xr0..3, bf_xi0..3    registered operands to the butterfly
//   bf_c1, bf_c2, bf_c3     butterfly controls
//   bf_xro, bf_xio          butterfly result
//   out_valid/out_ready     result handshake
//   out_xr, out_xi          captured result
//   out_idx, out_last       output index, high with out_valid at index 3
//   busy                    frame in progress
//   frame_cnt               completed frames, wraps modulo 256
// ---------------------------------------------------------------------------
module r4_butter_seq #(
  parameter int          W        = 4,
  parameter int          SETTLE   = 1,
  parameter logic [11:0] CTRL_SEQ = 12'b100_001_110_011
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*W-1:0] in_data,
  output logic [W-1:0]   bf_xr0,
  output logic [W-1:0]   bf_xr1,
  output logic [W-1:0]   bf_xr2,
  output logic [W-1:0]   bf_xr3,
  output logic [W-1:0]   bf_xi0,
  output logic [W-1:0]   bf_xi1,
  output logic [W-1:0]   bf_xi2,
  output logic [W-1:0]   bf_xi3,
  output logic           bf_c1,
  output logic           bf_c2,
  output logic           bf_c3,
  input  logic [W-1:0]   bf_xro,
  input  logic [W-1:0]   bf_xio,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_xr,
  output logic [W-1:0]   out_xi,
  output logic [1:0]     out_idx,
  output logic           out_last,
  output logic           busy,
  output logic [7:0]     frame_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_OUT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t           state, state_nxt;
  logic [1:0]       k;
  logic [3:0]       cnt;
  logic [8*W-1:0]   opnd;
  logic [2:0]       ctrl;
  logic             accept;
  logic             take;

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

  assign {bf_xi3, bf_xr3, bf_xi2, bf_xr2, bf_xi1, bf_xr1, bf_xi0, bf_xr0} = opnd;

  // Control word for the current index: {c1,c2,c3}.
  always_comb begin
    case (k)
      2'd0:    ctrl = CTRL_SEQ[2:0];
      2'd1:    ctrl = CTRL_SEQ[5:3];
      2'd2:    ctrl = CTRL_SEQ[8:6];
      default: ctrl = CTRL_SEQ[11:9];
    endcase
  end

  // NOTE: state registers use non-blocking assignments and reset
  // asynchronously, so every flop clears the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (accept)     state_nxt = ST_SETTLE;
        ST_SETTLE: if (cnt == '0)  state_nxt = ST_OUT;
        ST_OUT:    if (take)       state_nxt = (k == 2'd3) ? ST_IDLE : ST_SETTLE;
        default:                   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Controls are forced to zero in IDLE and otherwise follow the index, so
  // they stay stable throughout OUT until the result is taken.
  always_comb begin
    in_ready  = (state == ST_IDLE) && !flush;
    out_valid = (state == ST_OUT);
    busy      = (state != ST_IDLE);
    out_last  = (state == ST_OUT) && (out_idx == 2'd3);
    {bf_c1, bf_c2, bf_c3} = (state == ST_IDLE) ? 3'b000 : ctrl;
  end

  // Index, settle counter, operand and result registers. Operands are left
  // untouched by flush so the butterfly inputs keep the last frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= '0;
      cnt       <= '0;
      opnd      <= '0;
      out_xr    <= '0;
      out_xi    <= '0;
      out_idx   <= '0;
      frame_cnt <= '0;
    end else if (flush) begin
      k <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            opnd <= in_data;
            k    <= '0;
            cnt  <= CNT_INIT;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            out_xr  <= bf_xro;
            out_xi  <= bf_xio;
            out_idx <= k;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_OUT: begin
          if (take) begin
            if (k != 2'd3) begin
              k   <= k + 2'd1;
              cnt <= CNT_INIT;
            end else begin
              k         <= '0;
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r4_butter_seq.sv
// ---------------------------------------------------------------------------
// tb_r4_butter_seq
//   Directed bench for r4_butter_seq with a butterfly stub
//   (xro = {0,c1,c2,c3}, xio = ~xro). Expected results are queued at frame
//   accept and popped at each output handshake. A second instance with
//   SETTLE=3 checks the settle timing.
// ---------------------------------------------------------------------------
module tb_r4_butter_seq;

  localparam int W = 4;
  localparam int S = 1;

  typedef struct {
    logic [1:0]   idx;
    logic [W-1:0] xr;
    logic [W-1:0] xi;
    logic         last;
    logic [2:0]   c;
  } exp_t;

  logic clk, rst_n, flush, in_valid, out_ready;
  logic [8*W-1:0] in_data;
  logic in_ready, out_valid, out_last, busy, bf_c1, bf_c2, bf_c3;
  logic [W-1:0] bf_xr0, bf_xr1, bf_xr2, bf_xr3, bf_xi0, bf_xi1, bf_xi2, bf_xi3;
  logic [W-1:0] bf_xro, bf_xio, out_xr, out_xi;
  logic [1:0] out_idx;
  logic [7:0] frame_cnt;

  logic in_valid3, out_ready3;
  logic [8*W-1:0] in_data3;
  logic in_ready3, out_valid3, out_last3, busy3, c1_3, c2_3, c3_3;
  logic [W-1:0] xr0_3, xr1_3, xr2_3, xr3_3, xi0_3, xi1_3, xi2_3, xi3_3;
  logic [W-1:0] xro3, xio3, out_xr3, out_xi3;
  logic [1:0] out_idx3;
  logic [7:0] frame_cnt3;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic [7:0] exp_frames = 8'd0;

  logic [W-1:0] xr_tab [4] = '{4'h3, 4'h6, 4'h1, 4'h4};
  logic [2:0]   c_tab  [4] = '{3'b011, 3'b110, 3'b001, 3'b100};

  assign bf_xro = {1'b0, bf_c1, bf_c2, bf_c3};
  assign bf_xio = ~bf_xro;
  assign xro3   = {1'b0, c1_3, c2_3, c3_3};
  assign xio3   = ~xro3;

  r4_butter_seq #(.W(W), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bf_xr0(bf_xr0), .bf_xr1(bf_xr1), .bf_xr2(bf_xr2), .bf_xr3(bf_xr3),
    .bf_xi0(bf_xi0), .bf_xi1(bf_xi1), .bf_xi2(bf_xi2), .bf_xi3(bf_xi3),
    .bf_c1(bf_c1), .bf_c2(bf_c2), .bf_c3(bf_c3),
    .bf_xro(bf_xro), .bf_xio(bf_xio),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_xr(out_xr), .out_xi(out_xi), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  r4_butter_seq #(.W(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .bf_xr0(xr0_3), .bf_xr1(xr1_3), .bf_xr2(xr2_3), .bf_xr3(xr3_3),
    .bf_xi0(xi0_3), .bf_xi1(xi1_3), .bf_xi2(xi2_3), .bf_xi3(xi3_3),
    .bf_c1(c1_3), .bf_c2(c2_3), .bf_c3(c3_3),
    .bf_xro(xro3), .bf_xio(xio3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_xr(out_xr3), .out_xi(out_xi3), .out_idx(out_idx3), .out_last(out_last3),
    .busy(busy3), .frame_cnt(frame_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*W-1:0] opnds();
    return {bf_xi3, bf_xr3, bf_xi2, bf_xr2, bf_xi1, bf_xr1, bf_xi0, bf_xr0};
  endfunction

  task automatic send_frame(input logic [8*W-1:0] data);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("accept_opnd", opnds(), data);
    for (int i = 0; i < 4; i++)
      sb.push_back('{idx: 2'(i), xr: xr_tab[i], xi: ~xr_tab[i], last: (i == 3), c: c_tab[i]});
  endtask

  task automatic check_result(input string tag, input exp_t e, input logic [8*W-1:0] data);
    check({tag, "_idx"},  {30'd0, out_idx}, {30'd0, e.idx});
    check({tag, "_xr"},   {28'd0, out_xr}, {28'd0, e.xr});
    check({tag, "_xi"},   {28'd0, out_xi}, {28'd0, e.xi});
    check({tag, "_last"}, {31'd0, out_last}, {31'd0, e.last});
    check({tag, "_ctrl"}, {29'd0, bf_c1, bf_c2, bf_c3}, {29'd0, e.c});
    check({tag, "_opnd"}, opnds(), data);
  endtask

  // Consumes results of the current frame. A stall of five cycles is applied
  // at index stall_idx; junk drives in_valid with other data while busy;
  // stop_at returns with the result at that index still pending.
  task automatic drain(input logic [8*W-1:0] data, input int stall_idx,
                       input bit junk, input int stop_at);
    exp_t e;
    out_ready = 1'b1;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = ~data;
    end
    for (int r = 0; r < 4; r++) begin
      int n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      check("latency", n, S);
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
        return;
      end
      e = sb.pop_front();
      check_result("res", e, data);
      if (junk) check("busy_in_ready", {31'd0, in_ready}, 32'd0);
      if (r == stop_at) return;
      if (r == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check_result("stall", e, data);
        end
        out_ready = 1'b1;
      end
      if (r == 3) in_valid = 1'b0;
      tick();
    end
    exp_frames++;
    check("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_frames});
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [8*W-1:0] d;
    int n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in_valid3 = 1'b0; out_ready3 = 1'b0; in_data3 = '0;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ctrl", {29'd0, bf_c1, bf_c2, bf_c3}, 32'd0);
    check("rst_frames", {24'd0, frame_cnt}, 32'd0);
    check("rst_opnd", opnds(), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_busy", {31'd0, busy}, 32'd0);

    // Single frame, no back-pressure.
    d = 32'h1234_5678;
    send_frame(d);
    drain(d, 4, 1'b0, 4);

    // Reset while a result is pending.
    d = 32'h9ABC_DEF0;
    send_frame(d);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ctrl", {29'd0, bf_c1, bf_c2, bf_c3}, 32'd0);
    check("midrst_frames", {24'd0, frame_cnt}, 32'd0);
    check("midrst_xr", {28'd0, out_xr}, 32'd0);
    check("midrst_opnd", opnds(), 32'd0);
    sb.delete();
    exp_frames = 8'd0;
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-pressure at index 1 with in_valid held during the frame.
    d = 32'hA5C3_0F96;
    send_frame(d);
    drain(d, 1, 1'b1, 4);

    // Flush at index 2 while out_ready is high.
    d = 32'h7E81_4D2B;
    send_frame(d);
    drain(d, 4, 1'b0, 2);
    flush = 1'b1;
    tick();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_ctrl", {29'd0, bf_c1, bf_c2, bf_c3}, 32'd0);
    check("flush_frames", {24'd0, frame_cnt}, {24'd0, exp_frames});
    check("flush_opnd", opnds(), d);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h1111_1111;
    tick();
    check("flush_no_accept", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    check("post_flush_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();

    // 256 back-to-back frames: frame_cnt wraps through 255 -> 0.
    for (int f = 0; f < 256; f++) begin
      d = $urandom;
      send_frame(d);
      drain(d, 4, 1'b0, 4);
    end

    // SETTLE=3 instance: first result 3 edges after accept, then every 4.
    out_ready3 = 1'b1;
    in_valid3  = 1'b1;
    in_data3   = 32'hCAFE_F00D;
    tick();
    in_valid3 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (!out_valid3 && n < 20) begin tick(); n++; end
      check("s3_latency", n, 3);
      check("s3_idx", {30'd0, out_idx3}, r);
      check("s3_xr", {28'd0, out_xr3}, {28'd0, xr_tab[r]});
      tick();
    end
    check("s3_frames", {24'd0, frame_cnt3}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
